// File: rtl/conv_dw_seq_ctrl.sv
// conv_dw_seq_ctrl: channel sequencer for a single-channel depthwise KxK convolver.
// Per channel: load K*K weights, clear convolver, stream the fmap, drain and store results.
//
// Ports:
//   clk, global_rst_n        clock, async active-low reset
//   i_start / o_busy / o_done / o_err   job control and status (o_err sticky)
//   o_w_addr/o_w_rd/i_w_data weight memory port (read latency 1)
//   o_weight                 packed weights, word k at [W_BW*k +: W_BW]
//   o_f_addr/o_f_rd/i_f_data fmap memory port (read latency 1)
//   o_fmap/o_ce/o_conv_rst   convolver pixel, clock enable, synchronous clear
//   i_conv_result/i_valid_conv  convolver output
//   o_res_addr/o_res_we/o_res_data  result buffer write port
//
// Optional feature macro: CONV_SEQ_PAUSE_EN adds input i_pause, which stalls
// streaming and drain without skipping or repeating pixels.
module conv_dw_seq_ctrl #(
    parameter int I_BW         = 8,
    parameter int W_BW         = 8,
    parameter int O_CONV_BW    = 20,
    parameter int IF_SIZE_CONV = 28,
    parameter int K_SIZE       = 5,
    parameter int N_CH         = 4,
    parameter int A_BW         = 16,
    parameter int DRAIN_MAX    = 64
) (
    input  logic                          clk,
    input  logic                          global_rst_n,
    input  logic                          i_start,
`ifdef CONV_SEQ_PAUSE_EN
    input  logic                          i_pause,
`endif
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_err,
    output logic [A_BW-1:0]               o_w_addr,
    output logic                          o_w_rd,
    input  logic [W_BW-1:0]               i_w_data,
    output logic [K_SIZE*K_SIZE*W_BW-1:0] o_weight,
    output logic [A_BW-1:0]               o_f_addr,
    output logic                          o_f_rd,
    input  logic [I_BW-1:0]               i_f_data,
    output logic [I_BW-1:0]               o_fmap,
    output logic                          o_ce,
    output logic                          o_conv_rst,
    input  logic [O_CONV_BW-1:0]          i_conv_result,
    input  logic                          i_valid_conv,
    output logic [A_BW-1:0]               o_res_addr,
    output logic                          o_res_we,
    output logic [O_CONV_BW-1:0]          o_res_data
);

    localparam int OF   = IF_SIZE_CONV - K_SIZE + 1;
    localparam int NPIX = IF_SIZE_CONV * IF_SIZE_CONV;
    localparam int NK   = K_SIZE * K_SIZE;
    localparam int OFOF = OF * OF;
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int DR_W = $clog2(DRAIN_MAX + 1);

    localparam logic [A_BW-1:0] ONE_A  = A_BW'(1);
    localparam logic [A_BW-1:0] NK_A   = A_BW'(NK);
    localparam logic [A_BW-1:0] NKM1_A = A_BW'(NK - 1);
    localparam logic [A_BW-1:0] NPIX_A = A_BW'(NPIX);
    localparam logic [A_BW-1:0] NPM1_A = A_BW'(NPIX - 1);
    localparam logic [A_BW-1:0] OFOF_A = A_BW'(OFOF);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);
    localparam logic [DR_W-1:0] DR_LAST = DR_W'(DRAIN_MAX - 1);

    // Every fmap address of the job must be representable.
    if (longint'(N_CH) * longint'(NPIX) > (longint'(1) << A_BW)) begin : g_addr_chk
        $error("conv_dw_seq_ctrl: N_CH*NPIX does not fit in A_BW");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADW,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                        state_q;
    logic [CH_W-1:0]               ch_q;
    logic [A_BW-1:0]               k_q;
    logic [A_BW-1:0]               cidx_q;
    logic                          cap_q;
    logic                          w_rd_q;
    logic [A_BW-1:0]               w_addr_q;
    logic [NK*W_BW-1:0]            weight_q;
    logic [A_BW-1:0]               p_q;
    logic                          f_rd_q;
    logic [A_BW-1:0]               f_addr_q;
    logic                          fvld_q;
    logic                          ce_q;
    logic                          conv_rst_q;
    logic [A_BW-1:0]               out_cnt_q;
    logic [DR_W-1:0]               drain_cnt_q;
    logic                          res_we_q;
    logic [A_BW-1:0]               res_addr_q;
    logic [O_CONV_BW-1:0]          res_data_q;
    logic                          busy_q;
    logic                          done_q;
    logic                          err_q;

    logic                          pause;
`ifdef CONV_SEQ_PAUSE_EN
    assign pause = i_pause;
`else
    assign pause = 1'b0;
`endif

    logic [A_BW-1:0] ch_a;
    logic [A_BW-1:0] nxt_w_addr_d;
    logic [A_BW-1:0] res_addr_d;
    logic [A_BW-1:0] f_base_d;
    logic            in_run;
    logic            res_ok;
    logic            drain_fin;
    logic            drain_to;
    logic            last_ch;

    assign ch_a         = A_BW'(ch_q);
    assign nxt_w_addr_d = (ch_a + ONE_A) * NK_A;
    assign res_addr_d   = ch_a * OFOF_A + out_cnt_q;
    assign f_base_d     = ch_a * NPIX_A;
    assign in_run       = (state_q == S_STREAM) || (state_q == S_DRAIN);
    assign res_ok       = in_run && (out_cnt_q < OFOF_A);
    assign drain_fin    = (out_cnt_q == OFOF_A);
    // drain_cnt counts completed drain cycles, so this is the DRAIN_MAX-th one
    assign drain_to     = (drain_cnt_q == DR_LAST);
    assign last_ch      = (ch_q == LAST_CH);

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            k_q         <= '0;
            cidx_q      <= '0;
            cap_q       <= 1'b0;
            w_rd_q      <= 1'b0;
            w_addr_q    <= '0;
            weight_q    <= '0;
            p_q         <= '0;
            f_rd_q      <= 1'b0;
            f_addr_q    <= '0;
            fvld_q      <= 1'b0;
            ce_q        <= 1'b0;
            conv_rst_q  <= 1'b0;
            out_cnt_q   <= '0;
            drain_cnt_q <= '0;
            res_we_q    <= 1'b0;
            res_addr_q  <= '0;
            res_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            conv_rst_q <= 1'b0;
            done_q     <= 1'b0;
            res_we_q   <= 1'b0;
            fvld_q     <= 1'b0;

            // Weight words return one cycle after their read.
            cap_q  <= w_rd_q;
            cidx_q <= k_q;
            for (int i = 0; i < NK; i++) begin
                if (cap_q && (cidx_q == A_BW'(i))) begin
                    weight_q[i*W_BW +: W_BW] <= i_w_data;
                end
            end

            if (i_valid_conv) begin
                if (res_ok) begin
                    res_we_q   <= 1'b1;
                    res_data_q <= i_conv_result;
                    res_addr_q <= res_addr_d;
                    out_cnt_q  <= out_cnt_q + ONE_A;
                end else begin
                    err_q <= 1'b1;
                end
            end

            unique case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_q  <= S_LOADW;
                        busy_q   <= 1'b1;
                        err_q    <= 1'b0;
                        ch_q     <= '0;
                        w_rd_q   <= 1'b1;
                        w_addr_q <= '0;
                        k_q      <= '0;
                    end
                end
                S_LOADW: begin
                    if (k_q == NK_A) begin
                        state_q    <= S_CLEAR;
                        conv_rst_q <= 1'b1;
                    end else if (k_q == NKM1_A) begin
                        w_rd_q <= 1'b0;
                        k_q    <= NK_A;
                    end else begin
                        k_q      <= k_q + ONE_A;
                        w_addr_q <= w_addr_q + ONE_A;
                    end
                end
                S_CLEAR: begin
                    out_cnt_q   <= '0;
                    drain_cnt_q <= '0;
                    p_q         <= '0;
                    f_rd_q      <= 1'b1;
                    f_addr_q    <= f_base_d;
                    state_q     <= S_STREAM;
                end
                S_STREAM: begin
                    // A paused read is repeated later at the same address,
                    // so its returning data is not marked as a pixel.
                    ce_q   <= !pause;
                    fvld_q <= !pause;
                    if (!pause) begin
                        if (p_q == NPM1_A) begin
                            f_rd_q  <= 1'b0;
                            state_q <= S_DRAIN;
                        end else begin
                            p_q      <= p_q + ONE_A;
                            f_addr_q <= f_addr_q + ONE_A;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_fin || (drain_to && !pause)) begin
                        ce_q <= 1'b0;
                        if (!drain_fin) begin
                            err_q <= 1'b1;
                        end
                        if (last_ch) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            ch_q     <= ch_q + CH_W'(1);
                            state_q  <= S_LOADW;
                            w_rd_q   <= 1'b1;
                            w_addr_q <= nxt_w_addr_d;
                            k_q      <= '0;
                        end
                    end else begin
                        ce_q <= !pause;
                        if (!pause) begin
                            drain_cnt_q <= drain_cnt_q + DR_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_err      = err_q;
    assign o_w_addr   = w_addr_q;
    assign o_w_rd     = w_rd_q;
    assign o_weight   = weight_q;
    assign o_f_addr   = f_addr_q;
    assign o_f_rd     = f_rd_q;
    assign o_fmap     = fvld_q ? i_f_data : '0;
    assign o_ce       = ce_q;
    assign o_conv_rst = conv_rst_q;
    assign o_res_addr = res_addr_q;
    assign o_res_we   = res_we_q;
    assign o_res_data = res_data_q;

endmodule
